// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and constants for the audio-side ROM stream reader
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rom_rd_state_t;

  localparam int ROM_WORD_BYTES = 4;
  localparam int ROM_RD_LATENCY = 1;

endpackage

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - synchronous stream FIFO with occupancy output and flush
module stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         s_tdata,
  input  logic                     s_tvalid,
  output logic [WIDTH-1:0]         m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             push;
  logic             pop;

  // Writers gate on occupancy; a write into a full buffer is dropped.
  assign push     = s_tvalid && !flush && (occupancy != (AW+1)'(DEPTH));
  assign pop      = m_tvalid && m_tready && !flush;
  assign m_tvalid = (occupancy != '0);
  assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_tdata;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      occupancy <= occupancy + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/rom_stream_reader.sv
// rtl/rom_stream_reader.sv - ROM port-b block reader feeding a valid/ready stream
// Optional loop playback is enabled by defining ROM_READER_WRAP_EN.
module rom_stream_reader
  import audio_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             rom_en,
  output logic [31:0]      rom_addr,
  input  logic [31:0]      rom_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last
);

`ifdef ROM_READER_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int LAT   = ROM_RD_LATENCY;

  rom_rd_state_t    state;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] issued;
  logic [31:0]      nxt_addr;
  logic [31:0]      base_r;
  logic             en_last;
  logic [LAT-1:0]   pend_vld;
  logic [LAT-1:0]   pend_lst;
  logic [OCC_W-1:0] occ;
  logic [32:0]      fifo_out;
  logic             fifo_flush;

  logic             idle_start;
  logic [31:0]      base_aligned;
  logic [31:0]      issue_addr;
  logic [31:0]      issue_base;
  logic [CNT_W-1:0] issue_idx;
  logic [CNT_W-1:0] issue_cnt;
  logic             is_last;
  logic             room;
  logic             can_issue;

  // The first read goes out on the same edge that accepts start, so the
  // issue path muxes between the live inputs (IDLE) and the latched copies.
  always_comb begin
    base_aligned = base_addr & 32'hFFFF_FFFC;
    idle_start   = (state == IDLE) && start && !abort && (word_count != '0);
    issue_addr   = (state == IDLE) ? base_aligned : nxt_addr;
    issue_base   = (state == IDLE) ? base_aligned : base_r;
    issue_idx    = (state == IDLE) ? '0 : issued;
    issue_cnt    = (state == IDLE) ? word_count : count_r;
    is_last      = (issue_idx == issue_cnt - CNT_W'(1));
    room         = (int'(occ) + int'(rom_en) + $countones(pend_vld)) < FIFO_DEPTH;
    can_issue    = idle_start ||
                   ((state == RUN) && !abort && (issued < count_r) && room);
  end

  assign fifo_flush = abort && (state != IDLE);

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (fifo_flush),
    .s_tdata   ({pend_lst[LAT-1], rom_rd}),
    .s_tvalid  (pend_vld[LAT-1]),
    .m_tdata   (fifo_out),
    .m_tvalid  (out_valid),
    .m_tready  (out_ready),
    .occupancy (occ)
  );

  assign out_data = fifo_out[31:0];
  assign out_last = fifo_out[32];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      en_last  <= 1'b0;
      pend_vld <= '0;
      pend_lst <= '0;
      count_r  <= '0;
      issued   <= '0;
      nxt_addr <= '0;
      base_r   <= '0;
    end else begin
      done     <= 1'b0;
      rom_en   <= 1'b0;
      pend_vld <= (pend_vld << 1) | LAT'(rom_en);
      pend_lst <= (pend_lst << 1) | LAT'(en_last);

      if (can_issue) begin
        rom_en   <= 1'b1;
        rom_addr <= issue_addr;
        en_last  <= is_last;
        if (is_last && WRAP_EN) begin
          nxt_addr <= issue_base;
          issued   <= '0;
        end else begin
          nxt_addr <= issue_addr + 32'(ROM_WORD_BYTES);
          issued   <= issue_idx + CNT_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (word_count == '0) begin
              done <= 1'b1;
            end else begin
              busy    <= 1'b1;
              count_r <= word_count;
              base_r  <= base_aligned;
              state   <= (is_last && !WRAP_EN) ? DRAIN : RUN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            pend_vld <= '0;
          end else if (can_issue && is_last && !WRAP_EN) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            pend_vld <= '0;
          end else if (out_valid && out_ready && out_last) begin
            // Only the final word carries last, so nothing remains behind it.
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
